// File: rtl/bit_reorder_pkg.sv
// bit_reorder_pkg: mode codes and the word reorder function shared by the
// bit_reorder_unit datapath. Optional feature macro: BIT_REORDER_ROTATE_EN.
package bit_reorder_pkg;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_BITREV  = 2'b01;
    localparam logic [1:0] MODE_BYTEREV = 2'b10;
    localparam logic [1:0] MODE_ROTL    = 2'b11;

    // The function works on a MAX_WIDTH container; callers pass their
    // real width in w (an elaboration constant), so all the loops and
    // index arithmetic fold to plain wiring after inlining.
    localparam int MAX_WIDTH = 256;
    localparam int IDXW      = $clog2(MAX_WIDTH);

    function automatic logic [MAX_WIDTH-1:0] reorder(
        input logic [MAX_WIDTH-1:0] a,
        input logic [1:0]           mode,
        input logic [7:0]           amt,
        input int                   w
    );
        logic [MAX_WIDTH-1:0] s;
`ifndef BIT_REORDER_ROTATE_EN
        logic unused_amt;
        unused_amt = ^amt;
`endif
        s = a;
        case (mode)
            MODE_BITREV: begin
                for (int i = 0; i < MAX_WIDTH; i++)
                    if (i < w)
                        s[IDXW'(i)] = a[IDXW'(w - 1 - i)];
            end
            MODE_BYTEREV: begin
                // bit j of byte k comes from bit j of byte (w/8-1-k)
                for (int i = 0; i < MAX_WIDTH; i++)
                    if (i < w)
                        s[IDXW'(i)] =
                            a[IDXW'((w / 8 - 1 - i / 8) * 8 + i % 8)];
            end
`ifdef BIT_REORDER_ROTATE_EN
            MODE_ROTL: begin
                // result bit i comes from bit (i - amt) mod w
                for (int i = 0; i < MAX_WIDTH; i++)
                    if (i < w)
                        s[IDXW'(i)] =
                            a[IDXW'((i + w - int'(amt)) % w)];
            end
`endif
            default: s = a;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reorder_fifo.sv
// reorder_fifo: synchronous DEPTH x WIDTH result FIFO with occupancy count.
// Ports: clk, rst_n, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module reorder_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    import bit_reorder_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             do_push, do_pop;

    assign full_o  = (occ_q == CW'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)
            occ_d = occ_q + CW'(1);
        else if (do_pop && !do_push)
            occ_d = occ_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bit_reorder_unit.sv
// bit_reorder_unit: per-word pass / bit-rev / byte-rev / rotl into a FIFO.
// Ports: in_valid/in_ready/in_data/in_mode/in_amt, out_valid/out_ready/
// out_data, count (output handshakes). Rotate needs BIT_REORDER_ROTATE_EN.
module bit_reorder_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_mode,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [15:0]              count
);
    import bit_reorder_pkg::*;

    logic [WIDTH-1:0] result;
    logic             push, pop;
    logic             full, empty;
    logic [15:0]      count_q, count_d;

    assign result = WIDTH'(reorder(MAX_WIDTH'(in_data), in_mode,
                                   8'(in_amt), WIDTH));

    // No bypass: a full FIFO refuses input even on a same-cycle pop.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    reorder_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (result),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty)
    );

    assign count_d = pop ? count_q + 16'd1 : count_q;
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: tb/tb_bit_reorder_unit.sv
// tb_bit_reorder_unit: directed and streaming checks of bit_reorder_unit
// against a queue-based reference model (WIDTH=16, DEPTH=2).
module tb_bit_reorder_unit;

    localparam int W = 16;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_mode = '0;
    logic [3:0]    in_amt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [15:0]   count;

    always #5 clk = ~clk;

    bit_reorder_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                           input logic [1:0] m,
                                           input logic [3:0] amt);
        logic [W-1:0]   r;
        logic [2*W-1:0] t;
        r = a;
        case (m)
            2'b01: for (int i = 0; i < W; i++) r[i] = a[W-1-i];
            2'b10: r = {a[7:0], a[15:8]};
            2'b11: begin
`ifdef BIT_REORDER_ROTATE_EN
                t = {a, a} << amt;
                r = t[2*W-1:W];
`else
                t = '0;
                r = a;
`endif
            end
            default: r = a;
        endcase
        return r;
    endfunction

    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_count = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_count = '0;
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (exp_q.size() != D);
            do_pop  = (exp_q.size() != 0) && out_ready;
            if (do_pop) begin
                void'(exp_q.pop_front());
                exp_count = exp_count + 16'd1;
            end
            if (do_push)
                exp_q.push_back(model(in_data, in_mode, in_amt));
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() != D));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("count", 32'(count), 32'(exp_count));
        if (exp_q.size() != 0)
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] m,
                        input logic [3:0] a);
        bit rdy;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            step();
            n++;
        end while (!rdy && n < 200);
        if (!rdy)
            chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid && n < 200) begin
            step();
            n++;
        end
        if (out_valid)
            chk("drain_timeout", 32'd1, 32'd0);
    endtask

    bit done;

    initial begin
        logic [W-1:0] rot1;
`ifdef BIT_REORDER_ROTATE_EN
        rot1 = 16'h0003;
`else
        rot1 = 16'h8001;
`endif
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        send(16'hC255, 2'b01, 4'd0);
        chk("bitrev_valid", 32'(out_valid), 32'd1);
        chk("bitrev_data", 32'(out_data), 32'h0000AA43);
        step();
        chk("bitrev_count", 32'(count), 32'd1);
        chk("bitrev_empty", 32'(out_valid), 32'd0);

        send(16'h1234, 2'b10, 4'd0);
        chk("byterev_data", 32'(out_data), 32'h00003412);
        step();
        send(16'h8001, 2'b11, 4'd1);
        chk("rotl1_data", 32'(out_data), 32'(rot1));
        step();
        send(16'h8001, 2'b11, 4'd0);
        chk("rotl0_data", 32'(out_data), 32'h00008001);
        step();
        chk("count4", 32'(count), 32'd4);

        out_ready = 1'b0;
        send(16'h0A0A, 2'b00, 4'd0);
        send(16'h0B0B, 2'b00, 4'd0);
        chk("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0C0C;
        in_mode  = 2'b00;
        repeat (3) step();
        chk("held_ready", 32'(in_ready), 32'd0);
        chk("held_head", 32'(out_data), 32'h00000A0A);
        out_ready = 1'b1;
        send(16'h0C0C, 2'b00, 4'd0);
        drain();
        chk("bp_count", 32'(count), 32'd7);

        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(W'($urandom), 2'($urandom), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("stream_count", 32'(count), 32'd1007);
        chk("stream_left", 32'(exp_q.size()), 32'd0);

        out_ready = 1'b0;
        send(16'h1111, 2'b00, 4'd0);
        send(16'h2222, 2'b00, 4'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        send(16'hC255, 2'b01, 4'd0);
        chk("post_rst_data", 32'(out_data), 32'h0000AA43);
        step();
        chk("post_rst_count1", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
